uart_msg_sequencer: RTL
=======================

# uart_msg_sequencer

Parametrised message source for the UART transmit path. On a programmable interval tick it issues bytes of an arithmetic message (BASE, BASE+STEP, …) to the UART TX module over the TX_En_Sig / TX_Done_Sig handshake. It sends either one byte per tick or the whole message per tick, with an optional trailing checksum byte. It sits between the top level and the UART TX module, replacing fixed-table periodic senders.

## Interface
- DATA_W, 8, byte width.
- MSG_LEN, 6, payload bytes per message (≥1).
- BASE, 8'h0A, value of payload byte 0.
- STEP, 1, increment between consecutive payload bytes.
- INTERVAL, 25_000_000, tick period in CLK cycles (≥2).
- GAP, 0, idle cycles between bytes within a burst.
- IDX_W, $clog2(MSG_LEN+1), width of Byte_Idx.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  reset; synchronous, active-low.
- Enable  in  1  run control.
- Mode  in  1  0 = one byte per tick, 1 = whole message per tick.
- TX_Done_Sig  in  1  one-cycle pulse from the UART TX module when a byte completes.
- TX_En_Sig  out  1  request to the UART TX module; held high until done.
- TX_Data  out  DATA_W  byte to send; stable while TX_En_Sig is high.
- Byte_Idx  out  IDX_W  index of the byte currently or last presented.
- Busy  out  1  high from tick acceptance until the last byte of the unit completes.
- Msg_Done  out  1  one-cycle pulse after the final byte of a message completes.
- Overrun_Sig  out  1  one-cycle pulse when a tick is dropped.

## Operation
- Reset values: TX_En_Sig=0, TX_Data=0, Byte_Idx=0, Busy=0, Msg_Done=0, Overrun_Sig=0, interval counter=0, FSM=IDLE.
- Payload byte k = (BASE + k·STEP) mod 2^DATA_W, for k = 0…MSG_LEN-1.
- Interval counter runs only while Enable=1. It counts 0…INTERVAL-1 and wraps. A tick occurs on the cycle the count equals INTERVAL-1.
- FSM states: IDLE, SEND, WAIT_DONE, GAP.
  - IDLE + tick: latch Mode, go to SEND.
  - SEND: drive TX_Data/TX_En_Sig, go to WAIT_DONE.
  - WAIT_DONE + TX_Done_Sig: drop TX_En_Sig and advance the index.
    - Mode 0: return to IDLE.
    - Mode 1, last byte: return to IDLE.
    - Mode 1, more bytes: go to GAP, or straight to SEND if GAP=0.
  - GAP: after GAP cycles, go to SEND.
- Mode 0: each tick sends the next index. The index wraps to 0 after the last byte (payload or checksum). Msg_Done pulses when the wrap occurs.
- Mode 1: each tick sends indices 0…last.
- Mode is sampled only on an accepted tick. Changing it mid-unit has no effect until the next tick.
- A tick while Busy=1 is dropped: Overrun_Sig pulses and the FSM is unaffected.
- TX_Done_Sig while TX_En_Sig=0 is ignored.
- Enable falling mid-unit: the outstanding byte still completes (waits for done). Then the FSM goes to IDLE, the index resets to 0, the counter resets to 0, and no Msg_Done is issued.
- Reset asserted mid-operation: all state returns to reset values on the next edge, even with TX_En_Sig high.

## Timing
- Tick in cycle t → TX_En_Sig=1 and valid TX_Data/Byte_Idx in cycle t+1. Busy=1 from t+1.
- TX_Done_Sig seen in cycle d → TX_En_Sig=0 in cycle d+1.
- In Mode 1 the next TX_En_Sig rises in cycle d+2+GAP. The minimum low time is one cycle, even with GAP=0.
- Msg_Done pulses and Busy falls in cycle d+1 of the final byte's done.
- TX_Data holds its last value while TX_En_Sig is low.

## Configuration
- MSG_CHECKSUM_EN defined:
  - An extra byte is sent at index MSG_LEN: the two's-complement negation of the payload sum mod 2^DATA_W, so the sum of all bytes is 0.
  - This applies in both modes; the message is MSG_LEN+1 bytes long.
- Undefined: the message is MSG_LEN payload bytes only, and index MSG_LEN is never produced.

## Test plan
Bench settings: INTERVAL=20; TX stub pulses TX_Done_Sig 5 cycles after TX_En_Sig rises.

- Reset, Enable=1, Mode=0, defaults → first TX_En_Sig at cycle 20 (counted from Enable) with TX_Data=0x0A. Six ticks give 0A,0B,0C,0D,0E,0F; the 7th gives 0A. Msg_Done pulses once, after 0x0F.
- Mode=1, GAP=3 → one tick emits 0A…0F back-to-back. TX_En_Sig low for exactly 4 cycles between bytes; one Msg_Done; Busy low after.
- Mode=1 with a TX stub delay of 40 cycles → the ticks during the burst are dropped, each with one Overrun_Sig pulse, and the burst is uncorrupted.
- MSG_CHECKSUM_EN defined, Mode=1 → bytes 0A…0F then 0xB5; Msg_Done after 0xB5.
- Enable dropped while byte 2 (0x0C) is in flight → 0x0C completes, TX_En_Sig falls, no further bytes are sent. Re-enable → the next message starts at 0x0A after 20 cycles.
- RSTn low while TX_En_Sig=1 → all outputs at reset values on the next edge; a late TX_Done_Sig is ignored.

Source files
------------

// File: rtl/uart_msg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_msg_sequencer                                                         |
// | Periodic arithmetic-message source for the UART TX handshake; optional     |
// | trailing checksum byte enabled by defining MSG_CHECKSUM_EN.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_msg_sequencer #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       MSG_LEN  = 6,
    parameter logic [DATA_W-1:0] BASE     = 8'h0A,
    parameter int unsigned       STEP     = 1,
    parameter int unsigned       INTERVAL = 25_000_000,
    parameter int unsigned       GAP      = 0,
    parameter int unsigned       IDX_W    = $clog2(MSG_LEN+1)
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Enable,
    input  logic              Mode,
    input  logic              TX_Done_Sig,
    output logic              TX_En_Sig,
    output logic [DATA_W-1:0] TX_Data,
    output logic [IDX_W-1:0]  Byte_Idx,
    output logic              Busy,
    output logic              Msg_Done,
    output logic              Overrun_Sig
);

    localparam int unsigned c_CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int unsigned c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
`ifdef MSG_CHECKSUM_EN
    localparam int unsigned c_NUM_BYTES = MSG_LEN + 1;
`else
    localparam int unsigned c_NUM_BYTES = MSG_LEN;
`endif
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(c_NUM_BYTES - 1);

    function automatic logic [DATA_W-1:0] payload_byte(input int unsigned k);
        return BASE + DATA_W'(k) * DATA_W'(STEP);
    endfunction

`ifdef MSG_CHECKSUM_EN
    function automatic logic [DATA_W-1:0] payload_checksum();
        logic [DATA_W-1:0] s;
        s = '0;
        for (int unsigned k = 0; k < MSG_LEN; k++) s = s + payload_byte(k);
        return ~s + 1'b1;
    endfunction
    localparam logic [DATA_W-1:0] c_CHECKSUM = payload_checksum();
`endif

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [IDX_W-1:0]   r_next;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_tx_en;
    logic               r_mode;
    logic               r_busy;
    logic               r_msg_done;
    logic               r_overrun;

    logic               w_tick;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [DATA_W-1:0]  w_byte;

    assign w_tick = Enable && (r_cnt == c_CNT_W'(INTERVAL - 1));

    // An accepted tick presents its first byte directly from IDLE so the
    // request appears one cycle after the tick.
    assign w_sel_idx = (r_state == S_IDLE) ? (Mode ? '0 : r_next) : r_next;

    always_comb begin
        w_byte = payload_byte(32'(w_sel_idx));
`ifdef MSG_CHECKSUM_EN
        if (w_sel_idx == IDX_W'(MSG_LEN)) w_byte = c_CHECKSUM;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_gap_cnt  <= '0;
            r_next     <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_en    <= 1'b0;
            r_mode     <= 1'b0;
            r_busy     <= 1'b0;
            r_msg_done <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_msg_done <= 1'b0;
            r_overrun  <= 1'b0;

            if (!Enable || w_tick) r_cnt <= '0;
            else                   r_cnt <= r_cnt + 1'b1;

            if (w_tick && r_busy) r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (!Enable) begin
                        r_next <= '0;
                    end else if (w_tick) begin
                        r_mode    <= Mode;
                        r_tx_en   <= 1'b1;
                        r_tx_data <= w_byte;
                        r_idx     <= w_sel_idx;
                        r_busy    <= 1'b1;
                        r_state   <= S_WAIT_DONE;
                    end
                end
                S_SEND: begin
                    if (!Enable) begin
                        r_next  <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tx_en   <= 1'b1;
                        r_tx_data <= w_byte;
                        r_idx     <= w_sel_idx;
                        r_state   <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (TX_Done_Sig) begin
                        r_tx_en <= 1'b0;
                        if (!Enable) begin
                            // Aborted unit: no completion reported, restart at byte 0.
                            r_next  <= '0;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (r_idx == c_LAST_IDX) begin
                            r_next     <= '0;
                            r_msg_done <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_next <= r_idx + 1'b1;
                            if (!r_mode) begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else if (GAP == 0) begin
                                r_state <= S_SEND;
                            end else begin
                                r_gap_cnt <= '0;
                                r_state   <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (!Enable) begin
                        r_next  <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_gap_cnt == c_GAP_W'(GAP - 1)) begin
                        r_state <= S_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign TX_En_Sig   = r_tx_en;
    assign TX_Data     = r_tx_data;
    assign Byte_Idx    = r_idx;
    assign Busy        = r_busy;
    assign Msg_Done    = r_msg_done;
    assign Overrun_Sig = r_overrun;

endmodule
`default_nettype wire
